// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
//   Shared definitions for the RO-PUF measurement path. The sequencer, the pair
//   counters and the response comparator all use these.
//   Contents:
//     puf_state_e      sequencer state encoding
//     PUF_NUM_RO       ring oscillators behind the select muxes
//     PUF_SEL_W        RO select width
//     PUF_NUM_BITS     response bits per challenge
//     PUF_WINDOW       counter-enable cycles per response bit
//     PUF_WIN_W        window counter width
//     puf_idx_w()      width of a bit index for a given response length
// -----------------------------------------------------------------------------
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        MEASURE = 3'd2,
        SETTLE  = 3'd3,
        STROBE  = 3'd4,
        DONE    = 3'd5
    } puf_state_e;

    localparam int PUF_NUM_RO   = 16;
    localparam int PUF_SEL_W    = 4;
    localparam int PUF_NUM_BITS = 8;
    localparam int PUF_WINDOW   = 1024;
    localparam int PUF_WIN_W    = 11;

    // A single-bit response still needs a 1-bit index register.
    function automatic int puf_idx_w(input int num_bits);
        return (num_bits > 1) ? $clog2(num_bits) : 1;
    endfunction

endpackage

// File: rtl/puf_pair_map.sv
// -----------------------------------------------------------------------------
// puf_pair_map
//   Maps a response bit index and challenge word onto the RO pair measured for
//   that bit. Purely combinational; the sequencer registers the result.
//   sel_a = 2*bit_idx + challenge, sel_b = sel_a + 1, both wrapping at SEL_W bits
//   so that long responses reuse oscillators.
//   Ports:
//     bit_idx    in   BIT_W   response bit being measured
//     challenge  in   SEL_W   latched challenge word
//     sel_a      out  SEL_W   RO select for counter A
//     sel_b      out  SEL_W   RO select for counter B
// -----------------------------------------------------------------------------
module puf_pair_map #(
    parameter int SEL_W = 4,
    parameter int BIT_W = 3
) (
    input  logic [BIT_W-1:0] bit_idx,
    input  logic [SEL_W-1:0] challenge,
    output logic [SEL_W-1:0] sel_a,
    output logic [SEL_W-1:0] sel_b
);

    logic [BIT_W:0]   idx_x2;
    logic [SEL_W-1:0] base;

    assign idx_x2 = {bit_idx, 1'b0};
    // Truncation to SEL_W bits is the modulo-NUM_RO wrap.
    assign base   = SEL_W'(idx_x2);
    assign sel_a  = base + challenge;
    assign sel_b  = base + challenge + SEL_W'(1);

endmodule

// File: rtl/puf_challenge_seq.sv
// -----------------------------------------------------------------------------
// puf_challenge_seq
//   Measurement sequencer for the RO-PUF. For each response bit it selects an
//   RO pair, clears the pair counters, gates them for WINDOW cycles, lets them
//   settle one cycle, then strobes the comparator (capture on cmp_en fall).
//   All outputs are registered; they are decoded from the next state so they
//   line up with the state register.
//
//   Build option: define PUF_SEQ_ABORT_EN to add the 'abort' input, which
//   returns the sequencer to IDLE from any active state without a done pulse.
//
//   Ports:
//     clk        in   1       system clock
//     rst        in   1       synchronous active-high reset
//     start      in   1       begin a challenge (sampled only in IDLE)
//     challenge  in   SEL_W   challenge word, latched on start
//     abort      in   1       (PUF_SEQ_ABORT_EN only) cancel current challenge
//     sel_a      out  SEL_W   RO select, counter A
//     sel_b      out  SEL_W   RO select, counter B
//     cnt_rst    out  1       clear RO counters
//     cnt_en     out  1       RO counter gate
//     cmp_en     out  1       comparator strobe
//     resp_clr   out  1       comparator register clear (first bit only)
//     busy       out  1       challenge in progress
//     done       out  1       response complete pulse
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for start; selects hold their last value
//   CLEAR   | counters cleared, pair selected (resp_clr on bit 0)
//   MEASURE | counters gated for WINDOW cycles
//   SETTLE  | gate closed, counters settle before compare
//   STROBE  | cmp_en high; comparator captures as it falls
//   DONE    | one-cycle done pulse
// -----------------------------------------------------------------------------
import puf_pkg::*;

module puf_challenge_seq #(
    parameter int NUM_RO   = PUF_NUM_RO,
    parameter int SEL_W    = PUF_SEL_W,
    parameter int NUM_BITS = PUF_NUM_BITS,
    parameter int WINDOW   = PUF_WINDOW,
    parameter int WIN_W    = PUF_WIN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] challenge,
`ifdef PUF_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [SEL_W-1:0] sel_a,
    output logic [SEL_W-1:0] sel_b,
    output logic             cnt_rst,
    output logic             cnt_en,
    output logic             cmp_en,
    output logic             resp_clr,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = puf_idx_w(NUM_BITS);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);

    puf_state_e       state_q, state_d;
    logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [SEL_W-1:0] chal_q, chal_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d;
    logic [SEL_W-1:0] sel_b_q, sel_b_d;
    logic             cnt_rst_q, cnt_rst_d;
    logic             cnt_en_q, cnt_en_d;
    logic             cmp_en_q, cmp_en_d;
    logic             resp_clr_q, resp_clr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SEL_W-1:0] map_a, map_b;
    logic             abort_req;

`ifdef PUF_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Map from the next-state index/challenge so the selects are already
    // valid in the CLEAR cycle that starts each bit.
    puf_pair_map #(
        .SEL_W (SEL_W),
        .BIT_W (BIT_W)
    ) u_pair_map (
        .bit_idx   (bit_idx_d),
        .challenge (chal_d),
        .sel_a     (map_a),
        .sel_b     (map_b)
    );

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        win_cnt_d = win_cnt_q;
        chal_d    = chal_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    chal_d    = challenge;
                    bit_idx_d = '0;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                win_cnt_d = '0;
                state_d   = MEASURE;
            end
            MEASURE: begin
                if (win_cnt_q == WIN_LAST) begin
                    win_cnt_d = '0;
                    state_d   = SETTLE;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                end
            end
            SETTLE: begin
                state_d = STROBE;
            end
            STROBE: begin
                if (bit_idx_q == BIT_LAST) begin
                    state_d = DONE;
                end else begin
                    bit_idx_d = bit_idx_q + BIT_W'(1);
                    state_d   = CLEAR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides whatever the sequence wanted to do this cycle.
        if (abort_req && (state_q != IDLE)) begin
            state_d   = IDLE;
            win_cnt_d = '0;
        end

        cnt_rst_d  = (state_d == CLEAR);
        resp_clr_d = (state_d == CLEAR) && (bit_idx_d == '0);
        cnt_en_d   = (state_d == MEASURE);
        cmp_en_d   = (state_d == STROBE);
        done_d     = (state_d == DONE);
        busy_d     = (state_d != IDLE);

        // Selects change only on entry to CLEAR and otherwise hold.
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        if (state_d == CLEAR) begin
            sel_a_d = map_a;
            sel_b_d = map_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_idx_q  <= '0;
            win_cnt_q  <= '0;
            chal_q     <= '0;
            sel_a_q    <= '0;
            sel_b_q    <= '0;
            cnt_rst_q  <= 1'b0;
            cnt_en_q   <= 1'b0;
            cmp_en_q   <= 1'b0;
            resp_clr_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            win_cnt_q  <= win_cnt_d;
            chal_q     <= chal_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            cnt_rst_q  <= cnt_rst_d;
            cnt_en_q   <= cnt_en_d;
            cmp_en_q   <= cmp_en_d;
            resp_clr_q <= resp_clr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sel_a    = sel_a_q;
    assign sel_b    = sel_b_q;
    assign cnt_rst  = cnt_rst_q;
    assign cnt_en   = cnt_en_q;
    assign cmp_en   = cmp_en_q;
    assign resp_clr = resp_clr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_puf_challenge_seq.sv
// -----------------------------------------------------------------------------
// tb_puf_challenge_seq
//   Bench for puf_challenge_seq with WINDOW=4, NUM_BITS=8, NUM_RO=16.
//   Expected outputs come from a timeline model: cycle c after start acceptance
//   belongs to bit (c-1)/(WINDOW+3) at phase (c-1)%(WINDOW+3).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_puf_challenge_seq;

    localparam int NR    = 16;
    localparam int SW    = 4;
    localparam int NB    = 8;
    localparam int WIN   = 4;
    localparam int WW    = 3;
    localparam int PER   = WIN + 3;
    localparam int TOTAL = NB * PER + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [SW-1:0] challenge;
`ifdef PUF_SEQ_ABORT_EN
    logic          abort;
`endif
    logic [SW-1:0] sel_a, sel_b;
    logic          cnt_rst, cnt_en, cmp_en, resp_clr, busy, done;

    int checks = 0;
    int errors = 0;

    logic [SW-1:0] hold_a = '0;
    logic [SW-1:0] hold_b = '0;

    puf_challenge_seq #(
        .NUM_RO   (NR),
        .SEL_W    (SW),
        .NUM_BITS (NB),
        .WINDOW   (WIN),
        .WIN_W    (WW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .challenge (challenge),
`ifdef PUF_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .cnt_rst   (cnt_rst),
        .cnt_en    (cnt_en),
        .cmp_en    (cmp_en),
        .resp_clr  (resp_clr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // {sel_a, sel_b, cnt_rst, cnt_en, cmp_en, resp_clr, busy, done}
    function automatic logic [13:0] expect_at(input int c, input logic [SW-1:0] ch,
                                              input logic [SW-1:0] ha, input logic [SW-1:0] hb);
        int b, p, a;
        logic [SW-1:0] sa, sb;
        if (c >= 1 && c < TOTAL) begin
            b  = (c - 1) / PER;
            p  = (c - 1) % PER;
            a  = (2 * b + int'(ch)) % NR;
            sa = SW'(a);
            sb = SW'((a + 1) % NR);
            return {sa, sb, (p == 0), (p >= 1 && p <= WIN), (p == WIN + 2),
                    (p == 0 && b == 0), 1'b1, 1'b0};
        end else if (c == TOTAL) begin
            return {ha, hb, 4'b0000, 1'b1, 1'b1};
        end
        return {ha, hb, 6'b000000};
    endfunction

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = {sel_a, sel_b, cnt_rst, cnt_en, cmp_en, resp_clr, busy, done};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept a challenge at edge 0, then follow it cycle by cycle. p1/p2 pulse
    // start during cycle p (sampled at edge p); rc/ac assert rst/abort likewise.
    task automatic run(input string tag, input logic [SW-1:0] ch, input int p1, input int p2,
                       input int rc, input int ac, input int exp_dones);
        int kill;
        int dones;
        logic [13:0] e;
        kill  = 0;
        dones = 0;
        challenge = ch;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        challenge = SW'($urandom);
        for (int c = 1; c <= TOTAL + 1; c++) begin
            if (kill != 0) e = {hold_a, hold_b, 6'b000000};
            else           e = expect_at(c, ch, hold_a, hold_b);
            check($sformatf("%s cyc%0d", tag, c), e);
            if (done === 1'b1) dones++;
            if (kill == 0 && c < TOTAL) begin
                hold_a = e[13:10];
                hold_b = e[9:6];
            end
            if (kill != 0) break;
            start = (c == p1) || (c == p2);
            rst   = (c == rc);
`ifdef PUF_SEQ_ABORT_EN
            abort = (c == ac);
`endif
            if (c == rc) begin
                kill   = c;
                hold_a = '0;
                hold_b = '0;
            end else if (ac != 0 && c == ac) begin
                kill = c;
            end
            @(posedge clk); #1;
            start = 1'b0;
            rst   = 1'b0;
`ifdef PUF_SEQ_ABORT_EN
            abort = 1'b0;
`endif
        end
        checks++;
        if (dones != exp_dones) begin
            errors++;
            $display("FAIL %s done_count: got %0d expected %0d", tag, dones, exp_dones);
        end
    endtask

    typedef struct {
        logic [SW-1:0] ch;
        int            p1;
        int            p2;
        int            rc;
        int            exp_done;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{4'h0, 0,  0,  0,  1};   // pairs 0/1 .. 14/15
        tbl[1] = '{4'hF, 0,  0,  0,  1};   // bit0 wraps F/0, bit7 D/E
        tbl[2] = '{4'h3, 10, 57, 0,  1};   // start while busy and on DONE ignored
        tbl[3] = '{4'h9, 0,  0,  24, 0};   // reset in MEASURE of bit 3
        tbl[4] = '{4'h6, 0,  0,  0,  1};   // full run after mid-run reset

        rst       = 1'b1;
        start     = 1'b1;
        challenge = 4'h5;
`ifdef PUF_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("reset_hold%0d", i), 14'h0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", 14'h0);

        for (int i = 0; i < 5; i++)
            run($sformatf("tbl%0d", i), tbl[i].ch, tbl[i].p1, tbl[i].p2, tbl[i].rc, 0,
                tbl[i].exp_done);

`ifdef PUF_SEQ_ABORT_EN
        // Abort in STROBE of bit 5: cycle 5*PER+PER.
        run("abort_b5", 4'hA, 0, 0, 0, 5 * PER + PER, 0);
        run("after_abort", 4'h2, 0, 0, 0, 0, 1);
`endif

        for (int i = 0; i < 6; i++) begin
            logic [SW-1:0] rch;
            int rp1, rp2, rac, rexp;
            rch  = SW'($urandom_range(0, NR - 1));
            rp1  = $urandom_range(1, TOTAL);
            rp2  = $urandom_range(1, TOTAL);
            rac  = 0;
            rexp = 1;
`ifdef PUF_SEQ_ABORT_EN
            if ($urandom_range(0, 1) == 1) begin
                rac  = $urandom_range(1, TOTAL);
                rexp = 0;
            end
`endif
            if (rac != 0) begin
                if (rp1 >= rac) rp1 = 0;
                if (rp2 >= rac) rp2 = 0;
            end
            run($sformatf("rand%0d", i), rch, rp1, rp2, 0, rac, rexp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
